// File: rtl/tpsram_pkg.sv
// Shared definitions for the two-port SRAM: read-latency constants, FSM encoding
// and a byte-lane merge helper that other memories can reuse.
package tpsram_pkg;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_BW = 512;
    localparam int MERGE_BE = MERGE_BW / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [MERGE_BW-1:0] be_merge(
        input logic [MERGE_BW-1:0] old_word,
        input logic [MERGE_BW-1:0] new_word,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_BW-1:0] res;
        res = old_word;
        for (int k = 0; k < MERGE_BE; k++) begin
            if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tpsram_if.sv
// Write port, read port and status bundle of tpsram.
// master = requester side, slave = memory side.
interface tpsram_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) ();

    logic                   wr_en;
    logic [BW_ADDR-1:0]     wr_addr;
    logic [BW_DATA/8-1:0]   wr_be;
    logic [BW_DATA-1:0]     i_wr_data;
    logic                   rd_en;
    logic [BW_ADDR-1:0]     rd_addr;
    logic [BW_DATA-1:0]     o_rd_data;
    logic                   o_rd_valid;
    logic                   o_init_done;

    modport master (
        output wr_en, wr_addr, wr_be, i_wr_data, rd_en, rd_addr,
        input  o_rd_data, o_rd_valid, o_init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, i_wr_data, rd_en, rd_addr,
        output o_rd_data, o_rd_valid, o_init_done
    );

endinterface

// File: rtl/tpsram_rdpipe.sv
// Read output register stage, RD_LAT registers deep.
// Latency: RD_LAT cycles from in_vld to out_vld.
// Backpressure: none; accepts one result per cycle, out_dat holds between results.
import tpsram_pkg::*;

module tpsram_rdpipe #(
    parameter int BW_DATA = 32,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_vld,
    input  logic [BW_DATA-1:0] in_dat,
    output logic               out_vld,
    output logic [BW_DATA-1:0] out_dat
);

    logic               s1_vld;
    logic [BW_DATA-1:0] s1_dat;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) s1_dat <= in_dat;
        end
    end

    generate
        if (RD_LAT == RD_LAT_2) begin : g_lat2
            logic               s2_vld;
            logic [BW_DATA-1:0] s2_dat;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_dat <= s1_dat;
                end
            end

            assign out_vld = s2_vld;
            assign out_dat = s2_dat;
        end else begin : g_lat1
            assign out_vld = s1_vld;
            assign out_dat = s1_dat;
        end
    endgenerate

endmodule

// File: rtl/tpsram.sv
// Two-port SRAM with byte-lane write masking, same-address bypass and self-clearing init.
// Latency: RD_LAT (1 or 2) cycles from rd_en to o_rd_valid; init takes 2**BW_ADDR cycles.
// Backpressure: none; 1 read + 1 write per cycle in RUN, requests dropped during INIT.
import tpsram_pkg::*;

module tpsram #(
    parameter int                 BW_DATA  = 32,
    parameter int                 BW_ADDR  = 5,
    parameter int                 RD_LAT   = 1,
    parameter bit                 BYPASS   = 1'b1,
    parameter logic [BW_DATA-1:0] INIT_VAL = '0
) (
    input  logic    clk,
    input  logic    rstn,
    tpsram_if.slave bus
);

    localparam int DEPTH = 2 ** BW_ADDR;
    localparam int BW_BE = BW_DATA / 8;

    generate
        if (BW_DATA % 8 != 0) begin : g_bad_bw
            $error("tpsram: BW_DATA must be a multiple of 8");
        end
        if (BW_DATA > MERGE_BW) begin : g_too_wide
            $error("tpsram: BW_DATA exceeds the byte-merge helper width");
        end
        if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_bad_lat
            $error("tpsram: RD_LAT must be 1 or 2");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [BW_ADDR-1:0] init_cnt;
    logic [BW_DATA-1:0] mem [DEPTH];

    logic               wr_fire;
    logic               rd_fire;
    logic               collide;
    logic [BW_DATA-1:0] rd_word;
    logic [BW_DATA-1:0] merged;
    logic [BW_DATA-1:0] rd_dat;

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && (&init_cnt)) state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rstn)                 init_cnt <= '0;
        else if (state == ST_INIT) init_cnt <= init_cnt + BW_ADDR'(1);
    end

    assign wr_fire = bus.wr_en & (state == ST_RUN);
    assign rd_fire = bus.rd_en & (state == ST_RUN);

    // Array has no reset; INIT owns the write port until every word is cleared.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= INIT_VAL;
            end else if (wr_fire) begin
                for (int k = 0; k < BW_BE; k++) begin
                    if (bus.wr_be[k]) mem[bus.wr_addr][8*k +: 8] <= bus.i_wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_word = mem[bus.rd_addr];
    assign collide = wr_fire & (bus.wr_addr == bus.rd_addr);
    assign merged  = BW_DATA'(be_merge(MERGE_BW'(rd_word), MERGE_BW'(bus.i_wr_data),
                                       MERGE_BE'(bus.wr_be)));
    assign rd_dat  = (BYPASS && collide) ? merged : rd_word;

    tpsram_rdpipe #(
        .BW_DATA (BW_DATA),
        .RD_LAT  (RD_LAT)
    ) u_rdpipe (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (rd_fire),
        .in_dat  (rd_dat),
        .out_vld (bus.o_rd_valid),
        .out_dat (bus.o_rd_data)
    );

    assign bus.o_init_done = (state == ST_RUN);

endmodule

// File: tb/tb_tpsram.sv
// Bench for tpsram: two instances (RD_LAT=1/BYPASS=1 and RD_LAT=2/BYPASS=0) share one stimulus
// stream; a behavioural model is compared every cycle, plus directed literal expectations.
module tb_tpsram;

    localparam int          DEPTH = 32;
    localparam logic [31:0] INIT  = 32'hDEAD_BEEF;
    localparam int          LAT_A = 1;
    localparam int          LAT_B = 2;
    localparam bit          BYP_A = 1'b1;
    localparam bit          BYP_B = 1'b0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;

    always #5 clk = ~clk;

    tpsram_if #(.BW_DATA(32), .BW_ADDR(5)) ifa ();
    tpsram_if #(.BW_DATA(32), .BW_ADDR(5)) ifb ();

    assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
    assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
    assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
    assign ifa.i_wr_data = wr_data; assign ifb.i_wr_data = wr_data;
    assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
    assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

    tpsram #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(LAT_A), .BYPASS(BYP_A), .INIT_VAL(INIT))
        dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    tpsram #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(LAT_B), .BYPASS(BYP_B), .INIT_VAL(INIT))
        dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Behavioural model: array contents, init progress, and results due at a given edge.
    typedef struct {
        int          due;
        logic [31:0] dat;
    } rd_t;

    rd_t         pa[$];
    rd_t         pb[$];
    logic [31:0] mdl [DEPTH];
    int          init_left = 0;
    bit          known = 1'b0;
    int          cyc = 0;
    logic        ea_vld = 1'b0;
    logic        eb_vld = 1'b0;
    logic [31:0] ea_dat = '0;
    logic [31:0] eb_dat = '0;

    always @(posedge clk) begin : model
        logic [31:0] old_w;
        logic [31:0] mrg_w;
        rd_t         tmp;
        cyc++;
        if (!rstn) begin
            known = 1'b1;
            init_left = DEPTH;
            pa.delete();
            pb.delete();
            ea_vld = 1'b0; eb_vld = 1'b0;
            ea_dat = '0;   eb_dat = '0;
        end else begin
            if (init_left > 0) begin
                mdl[DEPTH - init_left] = INIT;
                init_left--;
            end else begin
                if (rd_en) begin
                    old_w = mdl[rd_addr];
                    mrg_w = old_w;
                    if (wr_en && wr_addr == rd_addr)
                        for (int k = 0; k < 4; k++)
                            if (wr_be[k]) mrg_w[8*k +: 8] = wr_data[8*k +: 8];
                    pa.push_back('{cyc + LAT_A - 1, BYP_A ? mrg_w : old_w});
                    pb.push_back('{cyc + LAT_B - 1, BYP_B ? mrg_w : old_w});
                end
                if (wr_en)
                    for (int k = 0; k < 4; k++)
                        if (wr_be[k]) mdl[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            end
            ea_vld = 1'b0;
            if (pa.size() > 0 && pa[0].due == cyc) begin
                tmp = pa.pop_front(); ea_vld = 1'b1; ea_dat = tmp.dat;
            end
            eb_vld = 1'b0;
            if (pb.size() > 0 && pb[0].due == cyc) begin
                tmp = pb.pop_front(); eb_vld = 1'b1; eb_dat = tmp.dat;
            end
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("a_init_done", 32'(ifa.o_init_done), 32'(init_left == 0));
            check("b_init_done", 32'(ifb.o_init_done), 32'(init_left == 0));
            check("a_rd_valid",  32'(ifa.o_rd_valid),  32'(ea_vld));
            check("b_rd_valid",  32'(ifb.o_rd_valid),  32'(eb_vld));
            check("a_rd_data",   ifa.o_rd_data, ea_dat);
            check("b_rd_data",   ifb.o_rd_data, eb_dat);
        end
    end

    // Delivered results with the edge they appeared on, for the directed checks.
    logic [31:0] qa_dat[$];
    logic [31:0] qb_dat[$];
    int          qa_cyc[$];
    int          qb_cyc[$];

    always @(posedge clk) begin
        #1;
        if (ifa.o_rd_valid === 1'b1) begin qa_dat.push_back(ifa.o_rd_data); qa_cyc.push_back(cyc); end
        if (ifb.o_rd_valid === 1'b1) begin qb_dat.push_back(ifb.o_rd_data); qb_cyc.push_back(cyc); end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic re, input logic [4:0] ra);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic xfer(input string name, input logic we, input logic [4:0] wa,
                        input logic [3:0] be, input logic [31:0] wd, input logic [4:0] ra,
                        input logic [31:0] expa, input logic [31:0] expb);
        int na;
        int nb;
        na = qa_dat.size();
        nb = qb_dat.size();
        drive(we, wa, be, wd, 1'b1, ra);
        idle(3);
        check({name, "_a_cnt"}, 32'(qa_dat.size() - na), 32'd1);
        check({name, "_b_cnt"}, 32'(qb_dat.size() - nb), 32'd1);
        if (qa_dat.size() > na) check({name, "_a"}, qa_dat[$], expa);
        if (qb_dat.size() > nb) check({name, "_b"}, qb_dat[$], expb);
    endtask

    // Release reset with a write and read to address 9 presented in the first INIT cycle.
    task automatic release_and_wait(input string name);
        int n;
        n = 0;
        @(negedge clk);
        rstn = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd9; wr_be = 4'hF; wr_data = 32'h1234_5678;
        rd_en = 1'b1; rd_addr = 5'd9;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
            if (ifa.o_init_done === 1'b1 && ifb.o_init_done === 1'b1) break;
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin : stim
        int na;
        int nb;
        idle(3);
        release_and_wait("init_cycles");
        idle(1);

        xfer("init_rd0",  1'b0, 5'd0, 4'h0, 32'h0, 5'd0,  INIT, INIT);
        xfer("init_rd15", 1'b0, 5'd0, 4'h0, 32'h0, 5'd15, INIT, INIT);
        xfer("init_rd31", 1'b0, 5'd0, 4'h0, 32'h0, 5'd31, INIT, INIT);
        xfer("init_wr_lost", 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, INIT, INIT);

        drive(1'b1, 5'd3, 4'hF, 32'h1122_3344, 1'b0, 5'd0);
        drive(1'b1, 5'd3, 4'b0101, 32'hAABB_CCDD, 1'b0, 5'd0);
        xfer("bytemask", 1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 32'h11BB_33DD, 32'h11BB_33DD);

        drive(1'b1, 5'd7, 4'hF, 32'h0, 1'b0, 5'd0);
        xfer("collide", 1'b1, 5'd7, 4'b0011, 32'hFFFF_FFFF, 5'd7, 32'h0000_FFFF, 32'h0);
        xfer("after_collide", 1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 32'h0000_FFFF, 32'h0000_FFFF);

        xfer("diff_rd5", 1'b1, 5'd4, 4'hF, 32'hCAFE_F00D, 5'd5, INIT, INIT);
        xfer("diff_rd4", 1'b0, 5'd0, 4'h0, 32'h0, 5'd4, 32'hCAFE_F00D, 32'hCAFE_F00D);

        drive(1'b1, 5'd10, 4'hF, 32'h0BAD_CAFE, 1'b0, 5'd0);
        xfer("wr_then_rd", 1'b0, 5'd0, 4'h0, 32'h0, 5'd10, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        xfer("be_zero", 1'b1, 5'd10, 4'h0, 32'hFFFF_FFFF, 5'd10, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        for (int i = 0; i < DEPTH; i++) drive(1'b1, 5'(i), 4'hF, 32'(i), 1'b0, 5'd0);
        na = qa_dat.size();
        nb = qb_dat.size();
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(i));
        idle(3);
        check("stream_a_cnt", 32'(qa_dat.size() - na), 32'd32);
        check("stream_b_cnt", 32'(qb_dat.size() - nb), 32'd32);
        if (qa_dat.size() >= na + 32 && qb_dat.size() >= nb + 32) begin
            for (int i = 0; i < DEPTH; i++) begin
                check("stream_a_dat", qa_dat[na + i], 32'(i));
                check("stream_b_dat", qb_dat[nb + i], 32'(i));
            end
            check("stream_a_span", 32'(qa_cyc[na + 31] - qa_cyc[na]), 32'd31);
            check("stream_b_span", 32'(qb_cyc[nb + 31] - qb_cyc[nb]), 32'd31);
            check("stream_shift",  32'(qb_cyc[nb] - qa_cyc[na]), 32'd1);
        end

        // Reset lands while dut_b's read is still in its second stage.
        na = qa_dat.size();
        nb = qb_dat.size();
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd20);
        @(negedge clk);
        rstn = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("rst_b_vld", 32'(ifb.o_rd_valid), 32'd0);
        check("rst_b_dat", ifb.o_rd_data, 32'h0);
        check("rst_a_dat", ifa.o_rd_data, 32'h0);
        idle(1);
        check("rst_a_cnt", 32'(qa_dat.size() - na), 32'd1);
        check("rst_b_cnt", 32'(qb_dat.size() - nb), 32'd0);
        release_and_wait("reinit_cycles");
        idle(1);
        xfer("reinit_rd20", 1'b0, 5'd0, 4'h0, 32'h0, 5'd20, INIT, INIT);
        xfer("reinit_rd3",  1'b0, 5'd0, 4'h0, 32'h0, 5'd3,  INIT, INIT);
        xfer("reinit_rd4",  1'b0, 5'd0, 4'h0, 32'h0, 5'd4,  INIT, INIT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tpsram.md
# tpsram

Parametrised two-port SRAM: one write port and one independent read port, both on the same clock. Adds byte-lane write masking, a selectable 1- or 2-cycle registered read latency, same-address write-to-read bypass and a self-clearing initialisation sequence after reset. It replaces single-port `spsram` instances wherever a producer and a consumer must access the array in the same cycle.

## Interface
- BW_DATA, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise)
- BW_ADDR, 5, address width; DEPTH = 2**BW_ADDR words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- BYPASS, 1, 1 = a same-cycle same-address read returns newly written bytes; 0 = returns old data
- INIT_VAL, 0, BW_DATA-bit value written to every word during initialisation
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  reset, synchronous, active-low
- o_init_done  out  1  high once initialisation is complete
- wr_en  in  1  write request, active high
- wr_addr  in  BW_ADDR  write address
- wr_be  in  BW_DATA/8  byte enables; bit k covers data bits [8k+7:8k]
- i_wr_data  in  BW_DATA  write data
- rd_en  in  1  read request, active high
- rd_addr  in  BW_ADDR  read address
- o_rd_data  out  BW_DATA  read data
- o_rd_valid  out  1  o_rd_data carries the result of a read request

## Operation
- Reset values (rstn low at a rising edge): o_init_done=0, o_rd_valid=0, o_rd_data=0, read pipeline cleared, FSM in INIT, init counter 0. Array contents are not reset directly.
- FSM states:
  - INIT: each cycle writes INIT_VAL to address = counter, then increments the counter. After the write to DEPTH-1, moves to RUN.
  - RUN: terminal state; left only by reset.
- During INIT, wr_en and rd_en are ignored. Requests are dropped, not queued, and no o_rd_valid is generated.
- Write in RUN: at a rising edge with wr_en=1, byte lane k of mem[wr_addr] is updated from i_wr_data only where wr_be[k]=1. wr_be=0 is a legal no-op.
- Read in RUN: rd_en=1 samples mem[rd_addr].
- Collision (wr_en, rd_en, wr_addr==rd_addr in the same cycle):
  - BYPASS=1: result is the merged word, i.e. new bytes where wr_be=1 and old bytes elsewhere.
  - BYPASS=0: result is the pre-write word.
- Write-then-read at the same address on consecutive cycles always returns the new data, independent of BYPASS.
- o_rd_data holds its last value while no read completes. o_rd_valid is high only in the cycles that deliver a result.
- Back-to-back reads are accepted every cycle; throughput is 1 read and 1 write per cycle.

## Timing
- Initialisation: after rstn returns high at edge R, INIT writes occupy edges R+1 … R+DEPTH. o_init_done rises after edge R+DEPTH. The first request accepted is the one sampled at edge R+DEPTH+1.
- RD_LAT=1: for rd_en sampled at edge N, o_rd_data/o_rd_valid update at edge N and are visible in cycle N..N+1.
- RD_LAT=2: same result, delayed one more register stage (updates at edge N+1).
- Reset mid-operation (any state): in-flight reads are discarded, with o_rd_valid low from the reset edge. INIT restarts at address 0 and the whole array is re-cleared.
- No combinational path from any input to any output.

## Structure
- Shared package: RD_LAT legal-value constants, FSM state encoding (ST_INIT, ST_RUN), and a function computing the byte-mask merge (old, new, be) for reuse by the bypass logic and other memories.
- One natural sub-module: `tpsram_rdpipe`, the RD_LAT-deep valid/data output register stage. The array, write masking, bypass mux and init FSM stay in the top module.

## Test plan
- Init: release rstn with INIT_VAL=32'hDEAD_BEEF and DEPTH=32 -> o_init_done rises exactly 32 cycles after release. Reading addresses 0, 15 and 31 returns 32'hDEAD_BEEF. A write issued during INIT is lost.
- Byte mask: write 32'h1122_3344 with be=4'hF to address 3, then 32'hAABB_CCDD with be=4'b0101 -> reading address 3 returns 32'h11BB_33DD.
- Streaming: write data=i to addresses 0..31, then 32 back-to-back reads -> o_rd_valid stays high for 32 consecutive cycles with data 0..31. Run for RD_LAT=1 and RD_LAT=2 and check the 1-cycle shift between them.
- Collision: address 7 holds 32'h0, then a same-cycle write of 32'hFFFF_FFFF (be=4'b0011) and read of address 7 -> returns 32'h0000_FFFF with BYPASS=1 and 32'h0 with BYPASS=0.
- Simultaneous different addresses: write address 4 and read address 5 in the same cycle -> the read returns the old mem[5], and the following read of address 4 returns the new data.
- Reset mid-read: assert rstn low with a read in flight -> no o_rd_valid pulse for it, o_rd_data=0, INIT reruns, and previously written addresses read back as INIT_VAL.
